// File: rtl/com_tracker.sv
// rtl/com_tracker.sv - EMA-smoothed, jump-gated centroid tracker with search/acquire/lock/coast states
module com_tracker #(
    parameter int SHIFT       = 2,
    parameter int JUMP_MAX    = 64,
    parameter int ACQ_FRAMES  = 3,
    parameter int LOST_FRAMES = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    input  logic        frame_done_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        locked_out
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, COAST} state_t;

    localparam int CNT_MAX = (ACQ_FRAMES > LOST_FRAMES) ? ACQ_FRAMES : LOST_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ACQ_N  = CNT_W'(ACQ_FRAMES);
    localparam logic [CNT_W-1:0] LOST_N = CNT_W'(LOST_FRAMES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [11:0] GATE_X = 12'(JUMP_MAX);
    localparam logic [10:0] GATE_Y = 11'(JUMP_MAX);

    state_t           state, state_nx;
    logic [10:0]      est_x, est_x_nx;
    logic [9:0]       est_y, est_y_nx;
    logic [CNT_W-1:0] hit_cnt, hit_nx, miss_cnt, miss_nx;
    logic             seen, seen_nx, pub;

    logic signed [11:0] dx, step_x;
    logic signed [10:0] dy, step_y;
    logic [11:0]        adx;
    logic [10:0]        ady;
    logic               in_gate;
    logic [10:0]        ema_x;
    logic [9:0]         ema_y;

    // Differences are one bit wider than the coordinates so they never wrap.
    always_comb begin
        dx      = $signed({1'b0, x_in}) - $signed({1'b0, est_x});
        dy      = $signed({1'b0, y_in}) - $signed({1'b0, est_y});
        step_x  = dx >>> SHIFT;
        step_y  = dy >>> SHIFT;
        adx     = dx[11] ? 12'(-dx) : 12'(dx);
        ady     = dy[10] ? 11'(-dy) : 11'(dy);
        in_gate = (adx <= GATE_X) && (ady <= GATE_Y);
        ema_x   = est_x + 11'(step_x);
        ema_y   = est_y + 10'(step_y);
    end

    always_comb begin
        state_nx = state;
        est_x_nx = est_x;
        est_y_nx = est_y;
        hit_nx   = hit_cnt;
        miss_nx  = miss_cnt;
        seen_nx  = seen;
        pub      = 1'b0;
        case (state)
            SEARCH: begin
                if (valid_in) begin
                    est_x_nx = x_in;
                    est_y_nx = y_in;
                    hit_nx   = ONE;
                    seen_nx  = 1'b1;
                    if (ACQ_FRAMES == 1) begin
                        state_nx = LOCKED;
                        pub      = 1'b1;
                    end else begin
                        state_nx = ACQUIRE;
                    end
                end
            end
            ACQUIRE: begin
                if (valid_in) begin
                    seen_nx = 1'b1;
                    if (in_gate) begin
                        est_x_nx = ema_x;
                        est_y_nx = ema_y;
                        hit_nx   = hit_cnt + ONE;
                        if (hit_nx >= ACQ_N) begin
                            state_nx = LOCKED;
                            pub      = 1'b1;
                        end
                    end else begin
                        est_x_nx = x_in;
                        est_y_nx = y_in;
                        hit_nx   = ONE;
                    end
                end
                if (frame_done_in) begin
                    if (!seen_nx) begin
                        state_nx = SEARCH;
                        hit_nx   = '0;
                    end
                    seen_nx = 1'b0;
                end
            end
            LOCKED, COAST: begin
                if (valid_in && in_gate) begin
                    est_x_nx = ema_x;
                    est_y_nx = ema_y;
                    seen_nx  = 1'b1;
                    miss_nx  = '0;
                    state_nx = LOCKED;
                    pub      = 1'b1;
                end
                // A same-cycle hit has already set seen_nx, so it closes the window as a hit.
                if (frame_done_in) begin
                    if (!seen_nx) begin
                        miss_nx = miss_cnt + ONE;
                        if (miss_nx >= LOST_N) begin
                            state_nx = SEARCH;
                            miss_nx  = '0;
                            hit_nx   = '0;
                        end else begin
                            state_nx = COAST;
                        end
                    end
                    seen_nx = 1'b0;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= SEARCH;
            est_x      <= '0;
            est_y      <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            seen       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            valid_out  <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_nx;
            est_x      <= est_x_nx;
            est_y      <= est_y_nx;
            hit_cnt    <= hit_nx;
            miss_cnt   <= miss_nx;
            seen       <= seen_nx;
            valid_out  <= pub;
            locked_out <= (state_nx == LOCKED) || (state_nx == COAST);
            if (pub) begin
                x_out <= est_x_nx;
                y_out <= est_y_nx;
            end
        end
    end

endmodule

// File: tb/tb_com_tracker.sv
// tb/tb_com_tracker.sv - scoreboard bench for com_tracker against an integer reference model
module tb_com_tracker;

    localparam int SHIFT    = 2;
    localparam int JUMP_MAX = 64;
    localparam int ACQ      = 3;
    localparam int LOST     = 8;
    localparam int S_SEARCH = 0, S_ACQUIRE = 1, S_LOCKED = 2, S_COAST = 3;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [10:0] x_in = '0;
    logic [9:0]  y_in = '0;
    logic        valid_in = 1'b0;
    logic        frame_done_in = 1'b0;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        locked_out;

    always #5 clk_in = ~clk_in;

    com_tracker #(
        .SHIFT(SHIFT), .JUMP_MAX(JUMP_MAX), .ACQ_FRAMES(ACQ), .LOST_FRAMES(LOST)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .x_in(x_in), .y_in(y_in),
        .valid_in(valid_in), .frame_done_in(frame_done_in),
        .x_out(x_out), .y_out(y_out), .valid_out(valid_out), .locked_out(locked_out)
    );

    typedef struct {
        bit pub;
        int x;
        int y;
        bit lk;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    int m_st = S_SEARCH, m_ex = 0, m_ey = 0, m_hit = 0, m_miss = 0, m_ox = 0, m_oy = 0;
    bit m_seen = 0;

    function automatic int floor_div(int d);
        int q = 1 << SHIFT;
        if (d >= 0) return d / q;
        return -((-d + q - 1) / q);
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(bit rst, bit v, int x, int y, bit fd);
        exp_t e;
        int   st0;
        bit   gate;
        e.pub = 0;
        if (rst) begin
            m_st = S_SEARCH; m_ex = 0; m_ey = 0; m_hit = 0; m_miss = 0;
            m_seen = 0; m_ox = 0; m_oy = 0;
        end else begin
            st0 = m_st;
            if (v) begin
                gate = (iabs(x - m_ex) <= JUMP_MAX) && (iabs(y - m_ey) <= JUMP_MAX);
                case (st0)
                    S_SEARCH: begin
                        m_ex = x; m_ey = y; m_hit = 1; m_seen = 1;
                        if (ACQ == 1) begin m_st = S_LOCKED; e.pub = 1; end
                        else m_st = S_ACQUIRE;
                    end
                    S_ACQUIRE: begin
                        m_seen = 1;
                        if (gate) begin
                            m_ex += floor_div(x - m_ex);
                            m_ey += floor_div(y - m_ey);
                            m_hit++;
                            if (m_hit >= ACQ) begin m_st = S_LOCKED; e.pub = 1; end
                        end else begin
                            m_ex = x; m_ey = y; m_hit = 1;
                        end
                    end
                    default: begin
                        if (gate) begin
                            m_ex += floor_div(x - m_ex);
                            m_ey += floor_div(y - m_ey);
                            m_seen = 1; m_miss = 0; m_st = S_LOCKED; e.pub = 1;
                        end
                    end
                endcase
            end
            if (fd && st0 != S_SEARCH) begin
                if (!m_seen) begin
                    if (st0 == S_ACQUIRE) begin
                        m_st = S_SEARCH; m_hit = 0;
                    end else begin
                        m_miss++;
                        if (m_miss >= LOST) begin m_st = S_SEARCH; m_miss = 0; m_hit = 0; end
                        else m_st = S_COAST;
                    end
                end
                m_seen = 0;
            end
            if (e.pub) begin m_ox = m_ex; m_oy = m_ey; end
        end
        e.x  = m_ox;
        e.y  = m_oy;
        e.lk = (m_st == S_LOCKED) || (m_st == S_COAST);
        sb_q.push_back(e);
    endtask

    task automatic step(bit rst, bit v, int x, int y, bit fd);
        @(negedge clk_in);
        rst_n_in      = !rst;
        valid_in      = v;
        x_in          = 11'(x);
        y_in          = 10'(y);
        frame_done_in = fd;
        model_step(rst, v, x, y, fd);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    // Each expected record describes the DUT outputs just after the edge that consumed its stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_valid_out", int'(valid_out), int'(e.pub));
                chk("sb_x_out", int'(x_out), e.x);
                chk("sb_y_out", int'(y_out), e.y);
                chk("sb_locked_out", int'(locked_out), int'(e.lk));
            end else if (valid_out) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_valid_out: got 1 expected 0 at %0t", $time);
            end
        end
    end

    initial begin
        int  x, y;
        bit  v, fd, rst, drop;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle();
        chk("reset_x_out", int'(x_out), 0);
        chk("reset_locked_out", int'(locked_out), 0);

        step(0, 1, 400, 300, 0);
        idle();
        chk("seed_no_valid_out", int'(valid_out), 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 404, 300, 0);
        idle();
        chk("acq2_no_valid_out", int'(valid_out), 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 408, 304, 0);
        idle();
        chk("acq_valid_out", int'(valid_out), 1);
        chk("acq_x_out", int'(x_out), 402);
        chk("acq_y_out", int'(y_out), 301);
        chk("acq_locked_out", int'(locked_out), 1);

        step(0, 0, 0, 0, 1);
        step(0, 1, 600, 301, 0);
        idle();
        chk("gate_no_valid_out", int'(valid_out), 0);
        chk("gate_x_held", int'(x_out), 402);
        step(0, 0, 0, 0, 1);
        idle();
        chk("coast_locked_out", int'(locked_out), 1);

        step(0, 1, 399, 301, 0);
        idle();
        chk("relock_valid_out", int'(valid_out), 1);
        chk("relock_x_out", int'(x_out), 401);

        step(0, 0, 0, 0, 1);
        step(0, 1, 401, 301, 1);
        idle();
        chk("simul_valid_out", int'(valid_out), 1);
        for (int i = 1; i <= 7; i++) begin
            step(0, 0, 0, 0, 1);
            idle();
        end
        chk("loss7_locked_out", int'(locked_out), 1);
        step(0, 0, 0, 0, 1);
        idle();
        chk("loss8_locked_out", int'(locked_out), 0);
        step(0, 1, 100, 100, 0);
        idle();
        chk("reseed_no_valid_out", int'(valid_out), 0);

        step(0, 0, 0, 0, 1);
        step(0, 1, 100, 100, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 100, 100, 0);
        idle();
        chk("relock2_locked_out", int'(locked_out), 1);
        step(1, 0, 0, 0, 0);
        idle();
        chk("midrst_x_out", int'(x_out), 0);
        chk("midrst_y_out", int'(y_out), 0);
        chk("midrst_locked_out", int'(locked_out), 0);
        chk("midrst_valid_out", int'(valid_out), 0);
        step(0, 1, 50, 60, 0);
        idle();
        chk("post_rst_seed_valid_out", int'(valid_out), 0);

        for (int i = 0; i < 4000; i++) begin
            drop = ((i / 300) % 3) == 2;
            rst  = ($urandom_range(0, 999) == 0);
            v    = !drop && ($urandom_range(0, 2) == 0);
            fd   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) begin
                x = $urandom_range(0, 2047);
                y = $urandom_range(0, 1023);
            end else begin
                x = clampi(m_ex + $urandom_range(0, 200) - 100, 0, 2047);
                y = clampi(m_ey + $urandom_range(0, 200) - 100, 0, 1023);
            end
            step(rst, v, x, y, fd);
        end
        idle();
        repeat (3) @(posedge clk_in);
        #3;
        chk("sb_queue_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
